bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one iteration per clock.
- Sits directly upstream of the per-digit BCD-to-7-segment decoders: each 4-bit slice of bcd drives one decoder.
- Start/done handshake lets a counter or switch-input stage request a conversion.
- Result is held stable between conversions so the displays do not flicker.

---
 rtl/bin2bcd_seq.sv | 127 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one iteration per clock).
// Define BIN2BCD_BLANK_LZ_EN to add the registered leading-zero blanking output.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
`ifdef BIN2BCD_BLANK_LZ_EN
    output logic [DIGITS-1:0]     blank,
`endif
    output logic [1:0]            dbg_state
);

    // Handshake: start is sampled only in IDLE (never queued); the accepting
    // edge captures bin. done is a one-cycle pulse that marks bcd/overflow as
    // freshly updated; both hold their value until the next done.

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [BIN_W-1:0] work_bin;
    logic [BCD_W-1:0] work_bcd;
    logic             ovf_sticky;
    logic [CNT_W-1:0] cnt;

    logic [BCD_W-1:0] adj_bcd;
    logic [BCD_W-1:0] next_bcd;
    logic             next_ovf;
    logic             last_iter;

    // Per-digit add-3 correction; digits never carry into each other.
    always_comb begin
        adj_bcd = work_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_bcd[4*i +: 4] >= 4'd5) begin
                adj_bcd[4*i +: 4] = work_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // The bit leaving the top digit would have started another digit, so it
    // marks overflow; the lower digits are unaffected and stay bin mod 10^DIGITS.
    assign next_bcd  = {adj_bcd[BCD_W-2:0], work_bin[BIN_W-1]};
    assign next_ovf  = ovf_sticky | adj_bcd[BCD_W-1];
    assign last_iter = (cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            work_bin   <= '0;
            work_bcd   <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
            bcd        <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        work_bin   <= bin;
                        work_bcd   <= '0;
                        ovf_sticky <= 1'b0;
                        cnt        <= '0;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work_bin   <= {work_bin[BIN_W-2:0], 1'b0};
                    work_bcd   <= next_bcd;
                    ovf_sticky <= next_ovf;
                    cnt        <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        bcd      <= next_bcd;
                        overflow <= next_ovf;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BIN2BCD_BLANK_LZ_EN
    logic [DIGITS-1:0] blank_next;
    logic              hi_zero;

    // Digit 0 is never blanked so a zero value still shows a single "0".
    always_comb begin
        blank_next = '0;
        hi_zero    = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero       = hi_zero & (next_bcd[4*i +: 4] == 4'd0);
            blank_next[i] = hi_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= '0;
        end else if (state == ST_SHIFT && last_iter) begin
            blank <= blank_next;
        end
    end
`endif

    assign busy      = (state == ST_SHIFT);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq: a 3-digit instance and a 2-digit instance
// for overflow cases, checked against hand-computed BCD values.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start2;
    logic [7:0]  bin, bin2;
    logic        busy, done, overflow;
    logic [11:0] bcd;
    logic [1:0]  dbg_state;
    logic        busy2, done2, overflow2;
    logic [7:0]  bcd2;
    logic [1:0]  dbg_state2;
`ifdef BIN2BCD_BLANK_LZ_EN
    logic [2:0]  blank;
    logic [1:0]  blank2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic        tsel = 1'b0;
    logic        m_busy, m_done, m_ovf;
    logic [11:0] m_bcd;
    logic [11:0] last_bcd [2];

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow),
`ifdef BIN2BCD_BLANK_LZ_EN
        .blank(blank),
`endif
        .dbg_state(dbg_state)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2),
`ifdef BIN2BCD_BLANK_LZ_EN
        .blank(blank2),
`endif
        .dbg_state(dbg_state2)
    );

    assign m_busy = tsel ? busy2 : busy;
    assign m_done = tsel ? done2 : done;
    assign m_ovf  = tsel ? overflow2 : overflow;
    assign m_bcd  = tsel ? {4'h0, bcd2} : bcd;
`ifdef BIN2BCD_BLANK_LZ_EN
    logic [2:0] m_blank;
    assign m_blank = tsel ? {1'b0, blank2} : blank;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full conversion on the selected instance with cycle-exact checks.
    task automatic run_conv(input logic sel, input logic [7:0] v, input logic [11:0] exp_bcd,
                            input logic exp_ovf, input logic [2:0] exp_blank);
        tsel = sel;
        @(negedge clk);
        if (sel) begin
            bin2 = v; start2 = 1'b1;
        end else begin
            bin = v; start = 1'b1;
        end
        @(posedge clk);
        #1;
        start  = 1'b0;
        start2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("busy_during", m_busy, 1);
            check("done_during", m_done, 0);
            check("bcd_hold", m_bcd, last_bcd[sel]);
            @(posedge clk);
            #1;
        end
        check("done_pulse", m_done, 1);
        check("busy_end", m_busy, 0);
        check("bcd_result", m_bcd, exp_bcd);
        check("ovf_result", m_ovf, exp_ovf);
`ifdef BIN2BCD_BLANK_LZ_EN
        check("blank_result", m_blank, exp_blank);
`else
        if (exp_blank === 3'bxxx) check("blank_unused", exp_blank, 0);
`endif
        last_bcd[sel] = exp_bcd;
        @(posedge clk);
        #1;
        check("done_single", m_done, 0);
        check("busy_after", m_busy, 0);
        check("bcd_after", m_bcd, exp_bcd);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; bin = '0; bin2 = '0;
        last_bcd[0] = '0;
        last_bcd[1] = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd, 0);
        check("rst_ovf", overflow, 0);
        check("rst_state", dbg_state, 0);
        check("rst_bcd2", bcd2, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_conv(1'b0, 8'd0,   12'h000, 1'b0, 3'b110);
        run_conv(1'b0, 8'd255, 12'h255, 1'b0, 3'b000);
        run_conv(1'b0, 8'd100, 12'h100, 1'b0, 3'b000);

        // A second start while shifting must be dropped, and bin may change freely.
        tsel = 1'b0;
        @(negedge clk);
        bin = 8'd42; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("mid_busy_n0", busy, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy_n2", busy, 1);
        @(negedge clk);
        bin = 8'd99; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("mid_busy_n3", busy, 1);
        for (int i = 4; i < 8; i++) begin
            @(posedge clk); #1;
            check("mid_busy", busy, 1);
            check("mid_done", done, 0);
            check("mid_bcd_hold", bcd, 12'h100);
        end
        @(posedge clk); #1;
        check("mid_done_n8", done, 1);
        check("mid_busy_n8", busy, 0);
        check("mid_bcd", bcd, 12'h042);
        @(posedge clk); #1;
        check("mid_busy_n9", busy, 0);
        check("mid_state_n9", dbg_state, 0);
        @(posedge clk); #1;
        check("mid_busy_n10", busy, 0);
        last_bcd[0] = 12'h042;

        run_conv(1'b1, 8'd200, 12'h000, 1'b1, 3'b010);
        run_conv(1'b1, 8'd123, 12'h023, 1'b1, 3'b000);
        run_conv(1'b1, 8'd99,  12'h099, 1'b0, 3'b000);

        // Reset in the middle of a conversion aborts it without a done pulse.
        run_conv(1'b0, 8'd57, 12'h057, 1'b0, 3'b100);
        tsel = 1'b0;
        @(negedge clk);
        bin = 8'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_bcd", bcd, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ovf", overflow, 0);
        check("abort_state", dbg_state, 0);
        last_bcd[0] = '0;
        last_bcd[1] = '0;
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_hold_done", done, 0);
            check("abort_hold_busy", busy, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_idle", busy, 0);
            check("post_rst_done", done, 0);
        end
        run_conv(1'b0, 8'd8, 12'h008, 1'b0, 3'b110);

        // start held high: one acceptance every 10 cycles, result steady between.
        @(negedge clk);
        bin = 8'd77; start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            check("cont_busy", busy, ((c % 10) < 8) ? 1 : 0);
            check("cont_done", done, ((c % 10) == 8) ? 1 : 0);
            check("cont_bcd", bcd, (c < 8) ? 12'h008 : 12'h077);
        end
        start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
